// File: rtl/relay_ctrl_pkg.sv
// Shared types for the relay register-transfer control path: FSM states,
// register IDs on the control bus, and small sizing helpers.
package relay_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        LOAD,
        HOLD,
        DONE
    } xfer_state_t;

    localparam int REG_ID_W = 4;
    typedef logic [REG_ID_W-1:0] reg_id_t;

    localparam reg_id_t REG_A    = 4'd0;
    localparam reg_id_t REG_B    = 4'd1;
    localparam reg_id_t REG_C    = 4'd2;
    localparam reg_id_t REG_D    = 4'd3;
    localparam reg_id_t REG_M1   = 4'd4;
    localparam reg_id_t REG_M2   = 4'd5;
    localparam reg_id_t REG_X    = 4'd6;
    localparam reg_id_t REG_Y    = 4'd7;
    localparam reg_id_t REG_J1   = 4'd8;
    localparam reg_id_t REG_J2   = 4'd9;
    localparam reg_id_t REG_INST = 4'd10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// ID-to-strobe decoder: drives exactly one bit of vec when en is high,
// all zeros otherwise. IDs outside 0..N-1 decode to zero.
module onehot_dec #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [W-1:0] id,
    input  logic         en,
    output logic [N-1:0] vec
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign vec[gi] = en && (id == W'(gi));
        end
    endgenerate

endmodule

// File: rtl/reg_xfer_seq.sv
// Register transfer sequencer: turns a (src, dst) command into a relay-safe
// sel/ld strobe sequence with ld strictly nested inside sel.
module reg_xfer_seq
    import relay_ctrl_pkg::*;
#(
    parameter int NREG       = 16,
    parameter int SETTLE_CYC = 2,
    parameter int LD_CYC     = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [$clog2(NREG)-1:0] src,
    input  logic [$clog2(NREG)-1:0] dst,
    input  logic                    ld_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NREG-1:0]         sel,
    output logic [NREG-1:0]         ld
);

    localparam int IDW = $clog2(NREG);
    localparam int CW  = $clog2(max3(SETTLE_CYC, LD_CYC, HOLD_CYC) + 1);

    xfer_state_t    state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [IDW-1:0] src_reg, dst_reg;
    logic           ld_en_reg;
    logic           busy_reg, done_reg, err_reg;
    logic [NREG-1:0] sel_reg, ld_reg;

    logic           range_ok;
    logic           cmd_ok;
    logic           accept;
    logic           reject;
    logic [IDW-1:0] sel_id;
    logic           sel_on;
    logic           ld_on;
    logic [NREG-1:0] sel_dec;
    logic [NREG-1:0] ld_dec;

    // With a power-of-two register count every encodable ID is addressable.
    generate
        if (NREG == (1 << IDW)) begin : g_pow2
            assign range_ok = 1'b1;
        end else begin : g_npow2
            assign range_ok = (int'(src) < NREG) && (int'(dst) < NREG);
        end
    endgenerate

    assign cmd_ok = range_ok && !(ld_en && (src == dst));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    if (cmd_ok) begin
                        accept     = 1'b1;
                        state_next = SEL;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SEL: begin
                if (cnt_reg == CW'(SETTLE_CYC - 1)) begin
                    state_next = ld_en_reg ? LOAD : HOLD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                if (cnt_reg == CW'(LD_CYC - 1)) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (cnt_reg == CW'(HOLD_CYC - 1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so the registered outputs
    // change on the same edge as the state, without a cycle of lag.
    assign sel_id = accept ? src : src_reg;
    assign sel_on = (state_next == SEL) || (state_next == LOAD) || (state_next == HOLD);
    assign ld_on  = (state_next == LOAD);

    onehot_dec #(.N(NREG), .W(IDW)) u_sel_dec (
        .id  (sel_id),
        .en  (sel_on),
        .vec (sel_dec)
    );

    onehot_dec #(.N(NREG), .W(IDW)) u_ld_dec (
        .id  (dst_reg),
        .en  (ld_on),
        .vec (ld_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            ld_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            sel_reg   <= '0;
            ld_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                src_reg   <= src;
                dst_reg   <= dst;
                ld_en_reg <= ld_en;
            end
            busy_reg <= (state_next != IDLE);
            done_reg <= (state_next == DONE);
            err_reg  <= reject;
            sel_reg  <= sel_dec;
            ld_reg   <= ld_dec;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;
    assign sel  = sel_reg;
    assign ld   = ld_reg;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Scoreboard bench for reg_xfer_seq: stimulus pushes expected transfer
// profiles, a negedge monitor pops and compares on each done/err pulse.
module tb_reg_xfer_seq;
    import relay_ctrl_pkg::*;

    localparam int NREG = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  src = '0;
    logic [3:0]  dst = '0;
    logic        ld_en = 1'b0;
    logic        busy, done, err;
    logic [15:0] sel, ld;

    reg_xfer_seq #(
        .NREG(NREG), .SETTLE_CYC(2), .LD_CYC(3), .HOLD_CYC(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .src   (src),
        .dst   (dst),
        .ld_en (ld_en),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .sel   (sel),
        .ld    (ld)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] sel;
        logic [15:0] ld;
        int          sel_cyc;
        int          ld_cyc;
        int          ld_first;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push_xfer(input string nm, input logic [3:0] s, input logic [3:0] d, input bit le);
        exp_t e;
        e.is_err   = 1'b0;
        e.name     = nm;
        e.sel      = 16'h0001 << s;
        e.ld       = le ? (16'h0001 << d) : 16'h0000;
        e.sel_cyc  = le ? 6 : 3;
        e.ld_cyc   = le ? 3 : 0;
        e.ld_first = le ? 3 : 0;
        e.lat      = le ? 7 : 4;
        sb.push_back(e);
    endtask

    task automatic push_err(input string nm);
        exp_t e;
        e.is_err   = 1'b1;
        e.name     = nm;
        e.sel      = '0;
        e.ld       = '0;
        e.sel_cyc  = 0;
        e.ld_cyc   = 0;
        e.ld_first = 0;
        e.lat      = 1;
        sb.push_back(e);
    endtask

    // Present a command for one accept edge, then scramble the inputs.
    task automatic issue(input logic [3:0] s, input logic [3:0] d, input bit le);
        start = 1'b1;
        src   = s;
        dst   = d;
        ld_en = le;
        @(posedge clk);
        #1;
        start = 1'b0;
        src   = 4'hF;
        dst   = 4'hE;
        ld_en = ~le;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor state
    bit          mon_on = 1'b0;
    logic        busy_p = 1'b0, err_p = 1'b0, rst_p = 1'b0;
    logic [15:0] sel_p = '0, ld_p = '0;
    int          w_cyc = 0, w_sel_cyc = 0, w_ld_cyc = 0, w_ld_first = 0;
    logic [15:0] w_sel = '0, w_ld = '0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (reset) begin
                w_cyc = 0; w_sel_cyc = 0; w_ld_cyc = 0; w_ld_first = 0;
                w_sel = '0; w_ld = '0;
            end else begin
                chk("sel_onehot0", 32'($onehot0(sel)), 32'd1);
                chk("ld_onehot0", 32'($onehot0(ld)), 32'd1);
                chk("ld_inside_sel", 32'((ld != 0) && (sel == 0)), 32'd0);
                if (ld != 0 && ld_p == 0)
                    chk("ld_rise_after_sel", 32'(sel_p != 0), 32'd1);
                if (ld_p != 0 && ld == 0 && !rst_p)
                    chk("ld_fall_before_sel", 32'(sel != 0), 32'd1);

                if (busy && !busy_p) begin
                    w_cyc = 0; w_sel_cyc = 0; w_ld_cyc = 0; w_ld_first = 0;
                    w_sel = '0; w_ld = '0;
                end
                if (busy) begin
                    w_cyc++;
                    w_sel |= sel;
                    w_ld  |= ld;
                    if (sel != 0) w_sel_cyc++;
                    if (ld != 0) begin
                        w_ld_cyc++;
                        if (w_ld_first == 0) w_ld_first = w_cyc;
                    end
                end

                if (err || done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got done=%0b err=%0b required no pulse", done, err);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_kind_err"}, 32'(err), 32'(e.is_err));
                        chk({e.name, "_kind_done"}, 32'(done), 32'(!e.is_err));
                        chk({e.name, "_pulse_sel"}, 32'(sel), 32'd0);
                        chk({e.name, "_pulse_ld"}, 32'(ld), 32'd0);
                        if (e.is_err) begin
                            chk({e.name, "_err_width"}, 32'(err_p), 32'd0);
                            chk({e.name, "_err_busy"}, 32'(busy), 32'd0);
                        end else begin
                            chk({e.name, "_busy"}, 32'(busy), 32'd1);
                            chk({e.name, "_sel"}, 32'(w_sel), 32'(e.sel));
                            chk({e.name, "_ld"}, 32'(w_ld), 32'(e.ld));
                            chk({e.name, "_sel_cyc"}, 32'(w_sel_cyc), 32'(e.sel_cyc));
                            chk({e.name, "_ld_cyc"}, 32'(w_ld_cyc), 32'(e.ld_cyc));
                            chk({e.name, "_ld_first"}, 32'(w_ld_first), 32'(e.ld_first));
                            chk({e.name, "_latency"}, 32'(w_cyc), 32'(e.lat));
                        end
                    end
                end
            end
            busy_p = busy;
            err_p  = err;
            sel_p  = sel;
            ld_p   = ld;
            rst_p  = reset;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ctl", 32'({busy, done, err}), 32'd0);
            chk("idle_sel", 32'(sel), 32'd0);
            chk("idle_ld", 32'(ld), 32'd0);
        end

        // A -> M2 with load
        push_xfer("a_to_m2", REG_A, REG_M2, 1'b1);
        issue(REG_A, REG_M2, 1'b1);
        wait_cycles(10);

        // M1 sel-only
        push_xfer("m1_sel_only", REG_M1, REG_A, 1'b0);
        issue(REG_M1, REG_A, 1'b0);
        wait_cycles(8);

        // src==dst reject, then a valid command on the very next cycle
        push_err("reject_d_d");
        push_xfer("b_to_x_after_err", REG_B, REG_X, 1'b1);
        start = 1'b1; src = REG_D; dst = REG_D; ld_en = 1'b1;
        @(posedge clk);
        #1;
        src = REG_B; dst = REG_X;
        @(posedge clk);
        #1;
        start = 1'b0; src = 4'hF; dst = 4'hE;
        wait_cycles(12);

        // start during LOAD must be ignored
        push_xfer("c_to_j1", REG_C, REG_J1, 1'b1);
        issue(REG_C, REG_J1, 1'b1);
        wait_cycles(2);
        start = 1'b1; src = REG_Y; dst = REG_D; ld_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cycles(12);

        // back-to-back: start held high across DONE is accepted in the next IDLE
        push_xfer("b2b_first", REG_D, REG_J2, 1'b1);
        push_xfer("b2b_second", REG_D, REG_J2, 1'b1);
        start = 1'b1; src = REG_D; dst = REG_J2; ld_en = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b0;
        wait_cycles(12);

        // reset in the middle of LOAD
        issue(REG_C, REG_X, 1'b1);
        wait_cycles(3);
        chk("pre_reset_ld", 32'(ld), 32'h0040);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ld", 32'(ld), 32'd0);
        chk("rst_busy_done", 32'({busy, done, err}), 32'd0);
        reset = 1'b0;
        wait_cycles(10);

        // recovery after reset
        push_xfer("inst_after_reset", REG_INST, REG_A, 1'b0);
        issue(REG_INST, REG_A, 1'b0);
        wait_cycles(8);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
